instr_encode_loader: RTL

//  Inverse of the instruction decoder: packs decoded fields (class, special, second-level, regs, imm)

---
 rtl/isa_pkg.sv | 69 ++++++
 rtl/instr_word_fifo.sv | 52 +++++
 rtl/instr_encode_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction loader: class codes, field
// positions, the halt opcode, the loader state encoding and the word encoder.
package isa_pkg;

    localparam logic [1:0] CLS_DATA_IMM = 2'b00;
    localparam logic [1:0] CLS_DATA_REG = 2'b01;
    localparam logic [1:0] CLS_LDST     = 2'b10;
    localparam logic [1:0] CLS_BRANCH   = 2'b11;

    localparam int CLS_HI      = 31;
    localparam int CLS_LO      = 30;
    localparam int SP_BIT      = 29;
    localparam int SEC_HI      = 28;
    localparam int SEC_LO      = 25;
    localparam int RD_HI       = 24;
    localparam int RD_LO       = 21;
    localparam int RS1_HI      = 20;
    localparam int RS1_LO      = 17;
    localparam int RS2_HI      = 16;
    localparam int RS2_LO      = 13;
    localparam int IMM_HI      = 15;
    localparam int IMM_SHORT_HI = 12;
    localparam int IMM_LO      = 0;
    localparam int OPC_HI      = 31;
    localparam int OPC_LO      = 25;

    localparam logic [6:0] HALT_OPC = 7'b1101000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loaderState_t;

    // Register-form classes (01/11) have bit 0 of the class code set; they
    // carry rs2 and a 13-bit immediate, the others carry a 16-bit immediate
    // with bit 16 left at zero.
    function automatic logic [31:0] encodeWord(
        input logic [1:0]  cls,
        input logic        sp,
        input logic [3:0]  second,
        input logic [3:0]  rd,
        input logic [3:0]  rs1,
        input logic [3:0]  rs2,
        input logic [15:0] imm,
        input logic        halt
    );
        logic [31:0] w;
        w = '0;
        if (halt) begin
            w[OPC_HI:OPC_LO] = HALT_OPC;
        end else begin
            w[CLS_HI:CLS_LO] = cls;
            w[SP_BIT]        = sp;
            w[SEC_HI:SEC_LO] = second;
            w[RD_HI:RD_LO]   = rd;
            w[RS1_HI:RS1_LO] = rs1;
            if (cls[0]) begin
                w[RS2_HI:RS2_LO]       = rs2;
                w[IMM_SHORT_HI:IMM_LO] = imm[IMM_SHORT_HI:IMM_LO];
            end else begin
                w[IMM_HI:IMM_LO] = imm;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Small synchronous FIFO buffering encoded instruction words between the
// field source and the instruction memory write port.
module instr_word_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                    (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign rdData = mem[rdPtr[PTR_W-1:0]];

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr[PTR_W-1:0]] <= wrData;
        end
    end

    // Pointer update; reset empties the buffer so an aborted load leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them into
// instruction memory starting at BASE_ADDR, stopping after the halt word.
module instr_encode_loader
    import isa_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic              in_special,
    input  logic [3:0]        in_second,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [15:0]       in_imm,
    input  logic              in_halt,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              field_err,
    output logic              overflow
);

    loaderState_t state;
    loaderState_t nextState;

    logic        accept;
    logic        pop;
    logic        startLoad;
    logic        writePhase;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [31:0] encodedWord;
    logic [31:0] fifoHead;
    logic        immTruncated;

    assign writePhase   = (state == ST_LOAD) || (state == ST_DRAIN);
    assign in_ready     = (state == ST_LOAD) && !fifoFull;
    assign accept       = in_valid && in_ready;
    assign imem_we      = writePhase && !fifoEmpty;
    assign pop          = imem_we && imem_ready;
    assign imem_wdata   = imem_we ? fifoHead : '0;
    assign startLoad    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy         = writePhase;
    assign done         = (state == ST_DONE);
    assign immTruncated = !in_halt && in_class[0] && (in_imm[15:13] != 3'b000);

    assign encodedWord = encodeWord(in_class, in_special, in_second, in_rd,
                                    in_rs1, in_rs2, in_imm, in_halt);

    instr_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) wordFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (accept),
        .pop    (pop),
        .wrData (encodedWord),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Loader state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: load until the halt bundle is taken, then drain the buffer.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (start) nextState = ST_LOAD;
            ST_LOAD:  if (accept && in_halt) nextState = ST_DRAIN;
            ST_DRAIN: if (fifoEmpty) nextState = ST_DONE;
            ST_DONE:  if (start) nextState = ST_LOAD;
            default:  nextState = ST_IDLE;
        endcase
    end

    // Write address, word counter and sticky flags; a new load clears them all.
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            field_err  <= 1'b0;
            overflow   <= 1'b0;
        end else if (startLoad) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            field_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                imem_addr  <= imem_addr + 1'b1;
                word_count <= word_count + 1'b1;
                if (&imem_addr) begin
                    overflow <= 1'b1;
                end
            end
            if (accept && immTruncated) begin
                field_err <= 1'b1;
            end
        end
    end

endmodule
